store_buffer: RTL

Write buffer sitting directly upstream of the data memory in the MEM stage. It queues CPU stores in a small FIFO and drains them to the data-memory port in cycles when the CPU is not using that port. Loads go to memory immediately, or are answered from the buffer. The CPU side mirrors the data-memory port signals, plus a stall output back to the hazard unit.

---
 rtl/store_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory: queues stores, drains them when the port is idle.
// Optional load forwarding from the buffer is enabled by defining STORE_FWD_EN.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        cpu_address,
  input  logic [DATA_W-1:0]        cpu_write_data,
  input  logic                     cpu_mem_read,
  input  logic                     cpu_mem_write,
  output logic [DATA_W-1:0]        cpu_read_data,
  output logic                     cpu_stall,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_write_data,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [DATA_W-1:0]        mem_read_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
`ifdef STORE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_q;

  logic              wr;
  logic              rd;
  logic              full;
  logic              empty;
  logic              enq;
  logic              drain;
  logic              load_wait;
  logic              hit;
  logic [DATA_W-1:0] fwd_data;
  logic              mread;

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0]  idx;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head + PTR_W'(i);
      if (rd && (CNT_W'(i) < count_q) && (addr_mem[idx] == cpu_address)) begin
        hit      = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign fwd_data = '0;
`endif

  // Port arbitration: a CPU load or store owns the port unless it is stalled or forwarded.
  always_comb begin
    wr        = cpu_mem_write;
    rd        = cpu_mem_read & ~cpu_mem_write;
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    enq       = wr & ~full;
    load_wait = ~FWD_EN & rd & ~empty;
    drain     = ~empty & ((~wr & ~rd) | hit | (wr & full) | load_wait);
    mread     = rd & ~hit & ~load_wait;
  end

  // Outputs are forced idle while reset is held.
  always_comb begin
    cpu_stall      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    cpu_read_data  = '0;
    if (!rst) begin
      cpu_stall = (wr & full) | load_wait;
      mem_read  = mread;
      mem_write = drain;
      if (mread) begin
        mem_address = cpu_address;
      end else if (drain) begin
        mem_address    = addr_mem[head];
        mem_write_data = data_mem[head];
      end
      if (hit) begin
        cpu_read_data = fwd_data;
      end else if (mread) begin
        cpu_read_data = mem_read_data;
      end
    end
  end

  assign count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_W'(1);
      end
      if (drain) begin
        head <= head + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(enq) - CNT_W'(drain);
    end
  end

  // Entry storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail] <= cpu_address;
      data_mem[tail] <= cpu_write_data;
    end
  end

endmodule
